// File: rtl/maquina_troco_pkg.sv
// Shared definitions for the coffee machine payment/change datapath.
// Holds the change dispenser state codes (also visible on SAIDA), the
// denomination codes used on DENOM and their face values in R$.
package pacote_cafe;

  // State codes are architectural: they are exported on SAIDA.
  typedef enum logic [2:0] {
    Ocioso    = 3'b000,
    Calcula   = 3'b001,
    Seleciona = 3'b010,
    Ejeta     = 3'b011,
    Solta     = 3'b100,
    Fim       = 3'b101,
    SemTroco  = 3'b110
  } estado_e;

  // Denomination codes as seen by the ejector mechanism.
  typedef enum logic [1:0] {
    DenomNenhuma = 2'b00,
    Denom2       = 2'b01,
    Denom5       = 2'b10,
    Denom1       = 2'b11
  } denom_e;

  localparam int unsigned Valor5 = 5;
  localparam int unsigned Valor2 = 2;
  localparam int unsigned Valor1 = 1;

  // Face value of a denomination code; "none" is worth nothing.
  function automatic int unsigned valor_denom(input denom_e d);
    int unsigned v;
    v = 0;
    case (d)
      Denom5:  v = Valor5;
      Denom2:  v = Valor2;
      Denom1:  v = Valor1;
      default: v = 0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/maquina_troco_seletor_moeda.sv
// seletor_moeda: purely combinational greedy denomination chooser.
// Picks the largest denomination not exceeding the amount owed among those
// still in stock, in the fixed order R$5, R$2, R$1. No backtracking: a
// choice that later strands the remainder is still taken.
//
// Ports:
//   restante_i  amount still owed (R$)
//   tem5_i      R$5 stock non-zero
//   tem2_i      R$2 stock non-zero
//   tem1_i      R$1 stock non-zero
//   denom_o     chosen denomination code (DenomNenhuma when none)
//   valido_o    a denomination could be chosen
module seletor_moeda
  import pacote_cafe::*;
#(
  parameter int unsigned W = 5
) (
  input  logic [W-1:0] restante_i,
  input  logic         tem5_i,
  input  logic         tem2_i,
  input  logic         tem1_i,
  output denom_e       denom_o,
  output logic         valido_o
);

  always_comb begin
    denom_o  = DenomNenhuma;
    valido_o = 1'b0;
    if ((restante_i >= W'(Valor5)) && tem5_i) begin
      denom_o  = Denom5;
      valido_o = 1'b1;
    end else if ((restante_i >= W'(Valor2)) && tem2_i) begin
      denom_o  = Denom2;
      valido_o = 1'b1;
    end else if ((restante_i >= W'(Valor1)) && tem1_i) begin
      denom_o  = Denom1;
      valido_o = 1'b1;
    end
  end

endmodule

// File: rtl/maquina_troco.sv
// maquina_troco: change/refund dispenser for the coffee machine.
// On INICIA it computes the amount owed (change or full refund), then pays
// it out one item at a time over a level handshake with the ejector, using
// greedy selection against internal per-denomination stock counters.
//
// Ports:
//   CLK        clock, all logic on posedge
//   RST        synchronous active-high reset
//   INICIA     one-cycle start request, honoured only when idle
//   MODO       0: change (CREDITO-PRECO), 1: full refund (CREDITO)
//   CREDITO    amount received, sampled with INICIA
//   PRECO      product price, sampled with INICIA
//   REPOR      restock pulse, honoured only when idle and INICIA low
//   ACK        ejector has taken the item (level)
//   EJETAR     item request valid
//   DENOM      denomination being ejected, stable while EJETAR is high
//   OCUPADO    busy (any state but idle)
//   CONCLUIDO  one-cycle pulse when the transaction is fully paid out
//   FALTA      sticky "could not pay" flag, cleared by next accepted INICIA
//   RESTANTE   amount still owed
//   SAIDA      current state code
module maquina_troco
  import pacote_cafe::*;
#(
  parameter int unsigned W          = 5,
  parameter int unsigned SW         = 4,
  parameter int unsigned STOCK5_INI = 4,
  parameter int unsigned STOCK2_INI = 8,
  parameter int unsigned STOCK1_INI = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         INICIA,
  input  logic         MODO,
  input  logic [W-1:0] CREDITO,
  input  logic [W-1:0] PRECO,
  input  logic         REPOR,
  input  logic         ACK,
  output logic         EJETAR,
  output logic [1:0]   DENOM,
  output logic         OCUPADO,
  output logic         CONCLUIDO,
  output logic         FALTA,
  output logic [W-1:0] RESTANTE,
  output logic [2:0]   SAIDA
);

  estado_e       state_q, state_d;
  logic [W-1:0]  restante_q, restante_d;
  denom_e        denom_q, denom_d;
  logic          falta_q, falta_d;
  logic [SW-1:0] stock5_q, stock5_d;
  logic [SW-1:0] stock2_q, stock2_d;
  logic [SW-1:0] stock1_q, stock1_d;

  denom_e sel_denom;
  logic   sel_valido;

  seletor_moeda #(
    .W (W)
  ) u_seletor (
    .restante_i (restante_q),
    .tem5_i     (stock5_q != '0),
    .tem2_i     (stock2_q != '0),
    .tem1_i     (stock1_q != '0),
    .denom_o    (sel_denom),
    .valido_o   (sel_valido)
  );

  // Next-state and datapath updates.
  always_comb begin
    state_d    = state_q;
    restante_d = restante_q;
    denom_d    = denom_q;
    falta_d    = falta_q;
    stock5_d   = stock5_q;
    stock2_d   = stock2_q;
    stock1_d   = stock1_q;

    case (state_q)
      Ocioso: begin
        if (INICIA) begin
          falta_d = 1'b0;
          if (!MODO && (PRECO > CREDITO)) begin
            // Customer underpaid: nothing to give back, flag it.
            restante_d = '0;
            state_d    = SemTroco;
          end else begin
            restante_d = MODO ? CREDITO : (CREDITO - PRECO);
            state_d    = Calcula;
          end
        end else if (REPOR) begin
          stock5_d = SW'(STOCK5_INI);
          stock2_d = SW'(STOCK2_INI);
          stock1_d = SW'(STOCK1_INI);
        end
      end

      Calcula: begin
        state_d = (restante_q == '0) ? Fim : Seleciona;
      end

      Seleciona: begin
        if (sel_valido) begin
          denom_d = sel_denom;
          state_d = Ejeta;
        end else begin
          state_d = SemTroco;
        end
      end

      Ejeta: begin
        if (ACK) begin
          // The selector only offers denominations with stock, so the
          // non-zero guards are belt-and-braces saturation at zero.
          unique case (denom_q)
            Denom5:  if (stock5_q != '0) stock5_d = stock5_q - SW'(1);
            Denom2:  if (stock2_q != '0) stock2_d = stock2_q - SW'(1);
            Denom1:  if (stock1_q != '0) stock1_d = stock1_q - SW'(1);
            default: ;
          endcase
          restante_d = restante_q - W'(valor_denom(denom_q));
          state_d    = Solta;
        end
      end

      Solta: begin
        if (!ACK) begin
          state_d = Calcula;
        end
      end

      Fim: begin
        denom_d = DenomNenhuma;
        state_d = Ocioso;
      end

      SemTroco: begin
        // RESTANTE is left holding the unpaid amount for the operator.
        falta_d = 1'b1;
        denom_d = DenomNenhuma;
        state_d = Ocioso;
      end

      default: begin
        state_d = Ocioso;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= Ocioso;
      restante_q <= '0;
      denom_q    <= DenomNenhuma;
      falta_q    <= 1'b0;
      stock5_q   <= SW'(STOCK5_INI);
      stock2_q   <= SW'(STOCK2_INI);
      stock1_q   <= SW'(STOCK1_INI);
    end else begin
      state_q    <= state_d;
      restante_q <= restante_d;
      denom_q    <= denom_d;
      falta_q    <= falta_d;
      stock5_q   <= stock5_d;
      stock2_q   <= stock2_d;
      stock1_q   <= stock1_d;
    end
  end

  // All outputs decode registered state only.
  always_comb begin
    EJETAR    = (state_q == Ejeta);
    OCUPADO   = (state_q != Ocioso);
    CONCLUIDO = (state_q == Fim);
    FALTA     = falta_q;
    DENOM     = denom_q;
    RESTANTE  = restante_q;
    SAIDA     = state_q;
  end

endmodule

// File: tb/tb_maquina_troco.sv
// Self-checking bench for maquina_troco: directed scenarios followed by
// randomized transactions, all checked against a greedy payout model.
module tb_maquina_troco;

  localparam int unsigned W   = 5;
  localparam int unsigned SW  = 4;
  localparam int S5I = 4;
  localparam int S2I = 8;
  localparam int S1I = 8;

  logic         CLK = 1'b0;
  logic         RST, INICIA, MODO, REPOR, ACK;
  logic [W-1:0] CREDITO, PRECO, RESTANTE;
  logic         EJETAR, OCUPADO, CONCLUIDO, FALTA;
  logic [1:0]   DENOM;
  logic [2:0]   SAIDA;

  int tests = 0;
  int fails = 0;
  int m5, m2, m1;  // model stock counts

  maquina_troco #(
    .W          (W),
    .SW         (SW),
    .STOCK5_INI (S5I),
    .STOCK2_INI (S2I),
    .STOCK1_INI (S1I)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .INICIA    (INICIA),
    .MODO      (MODO),
    .CREDITO   (CREDITO),
    .PRECO     (PRECO),
    .REPOR     (REPOR),
    .ACK       (ACK),
    .EJETAR    (EJETAR),
    .DENOM     (DENOM),
    .OCUPADO   (OCUPADO),
    .CONCLUIDO (CONCLUIDO),
    .FALTA     (FALTA),
    .RESTANTE  (RESTANTE),
    .SAIDA     (SAIDA)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int code_of(input int v);
    if (v == 5) return 2;
    if (v == 2) return 1;
    if (v == 1) return 3;
    return 0;
  endfunction

  // Greedy pick from the model's point of view; 0 means nothing payable.
  function automatic int greedy(input int owed);
    if (owed >= 5 && m5 > 0) return 5;
    if (owed >= 2 && m2 > 0) return 2;
    if (owed >= 1 && m1 > 0) return 1;
    return 0;
  endfunction

  task automatic reload_model();
    m5 = S5I;
    m2 = S2I;
    m1 = S1I;
  endtask

  task automatic check_stocks(input string tag);
    chk({tag, "_stock5"}, 32'(dut.stock5_q), m5);
    chk({tag, "_stock2"}, 32'(dut.stock2_q), m2);
    chk({tag, "_stock1"}, 32'(dut.stock1_q), m1);
  endtask

  // One full transaction from idle back to idle. dlo/dhi: cycles ACK is
  // withheld in EJETA; hlo/hhi: extra cycles ACK stays high in SOLTA.
  task automatic run_tx(input bit modo, input int cred, input int prec, input bit abuse,
                        input int dlo, input int dhi, input int hlo, input int hhi);
    int owed, pick, d, h;
    MODO    = modo;
    CREDITO = W'(cred);
    PRECO   = W'(prec);
    INICIA  = 1'b1;
    tick();
    INICIA  = 1'b0;
    REPOR   = 1'b0;
    chk("falta_cleared", FALTA, 0);
    chk("ocupado_start", OCUPADO, 1);
    if (!modo && prec > cred) begin
      chk("underpay_state", SAIDA, 6);
      chk("underpay_rest", RESTANTE, 0);
      chk("underpay_ejetar", EJETAR, 0);
      tick();
      chk("underpay_idle", SAIDA, 0);
      chk("underpay_falta", FALTA, 1);
      chk("underpay_rest_end", RESTANTE, 0);
      return;
    end
    owed = modo ? cred : cred - prec;
    chk("calc_state", SAIDA, 1);
    chk("calc_rest", RESTANTE, owed);
    while (1) begin
      if (owed == 0) begin
        tick();
        chk("fim_state", SAIDA, 5);
        chk("fim_concluido", CONCLUIDO, 1);
        tick();
        chk("done_state", SAIDA, 0);
        chk("done_concluido", CONCLUIDO, 0);
        chk("done_denom", DENOM, 0);
        chk("done_rest", RESTANTE, 0);
        chk("done_falta", FALTA, 0);
        return;
      end
      pick = greedy(owed);
      tick();
      chk("sel_state", SAIDA, 2);
      chk("sel_ejetar", EJETAR, 0);
      if (pick == 0) begin
        tick();
        chk("semtroco_state", SAIDA, 6);
        tick();
        chk("short_state", SAIDA, 0);
        chk("short_falta", FALTA, 1);
        chk("short_rest", RESTANTE, owed);
        chk("short_denom", DENOM, 0);
        chk("short_concluido", CONCLUIDO, 0);
        return;
      end
      tick();
      chk("ej_ejetar", EJETAR, 1);
      chk("ej_denom", DENOM, code_of(pick));
      chk("ej_rest", RESTANTE, owed);
      d = int'($urandom_range(dhi, dlo));
      repeat (d) begin
        if (abuse) begin
          INICIA  = 1'b1;
          REPOR   = 1'b1;
          CREDITO = W'($urandom);
          MODO    = 1'b1;
        end
        tick();
        INICIA = 1'b0;
        REPOR  = 1'b0;
        chk("wait_ejetar", EJETAR, 1);
        chk("wait_denom", DENOM, code_of(pick));
        chk("wait_rest", RESTANTE, owed);
      end
      ACK = 1'b1;
      tick();
      owed -= pick;
      if (pick == 5) m5--;
      else if (pick == 2) m2--;
      else m1--;
      chk("solta_state", SAIDA, 4);
      chk("solta_ejetar", EJETAR, 0);
      chk("solta_rest", RESTANTE, owed);
      chk("solta_denom", DENOM, code_of(pick));
      h = int'($urandom_range(hhi, hlo));
      repeat (h) begin
        tick();
        chk("solta_hold", SAIDA, 4);
      end
      ACK = 1'b0;
      tick();
      chk("back_calc", SAIDA, 1);
    end
  endtask

  initial begin
    RST = 1'b1; INICIA = 1'b0; MODO = 1'b0; REPOR = 1'b0; ACK = 1'b0;
    CREDITO = '0; PRECO = '0;
    tick();
    tick();
    RST = 1'b0;
    reload_model();
    chk("rst_saida", SAIDA, 0);
    chk("rst_ejetar", EJETAR, 0);
    chk("rst_ocupado", OCUPADO, 0);
    chk("rst_concluido", CONCLUIDO, 0);
    chk("rst_falta", FALTA, 0);
    chk("rst_denom", DENOM, 0);
    chk("rst_rest", RESTANTE, 0);
    check_stocks("rst");

    // Change of 7: R$5 then R$2.
    run_tx(1'b0, 10, 3, 1'b0, 1, 1, 0, 0);
    chk("tp1_stock5", 32'(dut.stock5_q), 3);
    chk("tp1_stock2", 32'(dut.stock2_q), 7);
    check_stocks("tp1");

    // Full refund of 9, price ignored.
    run_tx(1'b1, 9, 20, 1'b0, 0, 2, 0, 1);
    check_stocks("tp2");

    // Restock in idle.
    REPOR = 1'b1;
    tick();
    REPOR = 1'b0;
    reload_model();
    check_stocks("repor");

    // ACK while idle has no effect.
    ACK = 1'b1;
    tick();
    tick();
    ACK = 1'b0;
    chk("ack_idle_state", SAIDA, 0);
    check_stocks("ack_idle");

    // Underpayment, then exact payment.
    run_tx(1'b0, 5, 7, 1'b0, 0, 0, 0, 0);
    run_tx(1'b0, 4, 4, 1'b0, 0, 0, 0, 0);

    // ACK withheld 20 cycles, then held 5 cycles; busy-time INICIA/REPOR.
    run_tx(1'b0, 9, 0, 1'b1, 20, 20, 4, 4);
    check_stocks("ackhold");

    // Exhaust R$1 coins, then 6 fails after one R$5.
    repeat (S1I) run_tx(1'b1, 1, 0, 1'b0, 0, 1, 0, 0);
    chk("no_r1", 32'(dut.stock1_q), 0);
    run_tx(1'b0, 6, 0, 1'b0, 0, 0, 0, 0);
    chk("tp3_rest", RESTANTE, 1);
    chk("tp3_falta", FALTA, 1);

    // INICIA and REPOR together: INICIA wins, stocks untouched.
    REPOR = 1'b1;
    run_tx(1'b1, 0, 0, 1'b0, 0, 0, 0, 0);
    check_stocks("inicia_wins");

    // Reset in the middle of EJETA.
    MODO = 1'b1; CREDITO = W'(9); INICIA = 1'b1;
    tick();
    INICIA = 1'b0;
    tick();
    tick();
    chk("prerst_ejetar", EJETAR, 1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    reload_model();
    chk("midrst_ejetar", EJETAR, 0);
    chk("midrst_saida", SAIDA, 0);
    chk("midrst_rest", RESTANTE, 0);
    chk("midrst_denom", DENOM, 0);
    check_stocks("midrst");

    // Randomized transactions.
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(5, 0) == 0) begin
        REPOR = 1'b1;
        tick();
        REPOR = 1'b0;
        reload_model();
        check_stocks("rnd_repor");
      end else begin
        REPOR = ($urandom_range(7, 0) == 0);
        run_tx(1'($urandom), int'($urandom_range(31, 0)), int'($urandom_range(31, 0)),
               1'($urandom), 0, 3, 0, 2);
        check_stocks("rnd");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
